// File: rtl/axi_r_arb2_pkg.sv
// axi_r_arb2_pkg: shared state and grant-index types for the two-way AXI read arbiter
package axi_arb_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef logic gnt_t;
endpackage

// File: rtl/axi_r_arb2_if.sv
// axi_r_arb2_if: AXI read channel (AR + R) bundle; master drives AR and RREADY, slave drives ARREADY and R
interface axi_r_arb2_if #(
    parameter int ARADDR_W = 32,
    parameter int RDATA_W  = 128
);
    logic                arvalid;
    logic                arready;
    logic [ARADDR_W-1:0] araddr;
    logic [1:0]          arburst;
    logic [7:0]          arlen;
    logic                rvalid;
    logic                rready;
    logic [RDATA_W-1:0]  rdata;
    logic [1:0]          rresp;
    logic                rlast;
    modport master (
        output arvalid, araddr, arburst, arlen, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );
    modport slave (
        input  arvalid, araddr, arburst, arlen, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi_r_arb2_rr.sv
// rr_arb2: combinational 2-way round-robin picker; on a tie the requester that did not win last time wins
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_t       last,
    output logic [1:0] gnt_onehot,
    output gnt_t       gnt_idx
);
    always_comb begin
        gnt_idx    = (req == 2'b11) ? ~last : req[1];
        gnt_onehot = (req == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
    end
endmodule

// File: rtl/axi_r_arb2.sv
// axi_r_arb2: shares one downstream AXI read channel between two requesters, one burst at a time
module axi_r_arb2
    import axi_arb_pkg::*;
#(
    parameter int ARADDR_W = 32,
    parameter int RDATA_W  = 128
) (
    input  logic         clk,
    input  logic         rst,
    axi_r_arb2_if.slave  m0,
    axi_r_arb2_if.slave  m1,
    axi_r_arb2_if.master s,
    output logic         len_err
);
    state_t              state, state_nxt;
    gnt_t                grant, last_grant, gnt_idx;
    logic [1:0]          gnt_oh;
    logic [ARADDR_W-1:0] addr_q;
    logic [1:0]          burst_q;
    logic [7:0]          len_q, cnt;
    logic                ar_hs, beat, m0_sel, m1_sel;

    rr_arb2 u_rr (
        .req        ({m1.arvalid, m0.arvalid}),
        .last       (last_grant),
        .gnt_onehot (gnt_oh),
        .gnt_idx    (gnt_idx)
    );

    always_comb begin
        ar_hs      = state == IDLE && |gnt_oh;
        m0_sel     = state == DATA && !grant;
        m1_sel     = state == DATA && grant;
        m0.arready = state == IDLE && gnt_oh[0];
        m1.arready = state == IDLE && gnt_oh[1];
        s.arvalid  = state == ADDR;
        s.araddr   = addr_q;
        s.arburst  = burst_q;
        s.arlen    = len_q;
        s.rready   = (m0_sel && m0.rready) || (m1_sel && m1.rready);
        beat       = s.rvalid && s.rready;
        m0.rvalid  = m0_sel && s.rvalid;
        m0.rdata   = m0_sel ? s.rdata : {RDATA_W{1'b0}};
        m0.rresp   = m0_sel ? s.rresp : 2'b00;
        m0.rlast   = m0_sel && s.rlast;
        m1.rvalid  = m1_sel && s.rvalid;
        m1.rdata   = m1_sel ? s.rdata : {RDATA_W{1'b0}};
        m1.rresp   = m1_sel ? s.rresp : 2'b00;
        m1.rlast   = m1_sel && s.rlast;
        state_nxt  = ar_hs ? ADDR :
                     (state == ADDR && s.arready) ? DATA :
                     (state == DATA && beat && s.rlast) ? IDLE : state;
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    // only RLAST ends a burst; a count disagreement just raises the sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 8'd0;
            len_err    <= 1'b0;
            addr_q     <= '0;
            burst_q    <= 2'b00;
            len_q      <= 8'd0;
        end else begin
            if (ar_hs) begin
                grant   <= gnt_idx;
                cnt     <= 8'd0;
                addr_q  <= gnt_idx ? m1.araddr : m0.araddr;
                burst_q <= gnt_idx ? m1.arburst : m0.arburst;
                len_q   <= gnt_idx ? m1.arlen : m0.arlen;
            end
            if (beat) begin
                cnt <= cnt + 8'd1;
                if (s.rlast != (cnt == len_q))
                    len_err <= 1'b1;
                if (s.rlast)
                    last_grant <= grant;
            end
        end
    end
endmodule

// File: tb/tb_axi_r_arb2.sv
// tb_axi_r_arb2: table-driven bursts plus directed backpressure, reset and back-to-back sequences
module tb_axi_r_arb2;
    logic clk = 1'b0;
    logic rst;
    logic len_err;
    int   total = 0;
    int   bad = 0;

    axi_r_arb2_if #(.ARADDR_W(32), .RDATA_W(128)) m0 ();
    axi_r_arb2_if #(.ARADDR_W(32), .RDATA_W(128)) m1 ();
    axi_r_arb2_if #(.ARADDR_W(32), .RDATA_W(128)) s ();

    axi_r_arb2 #(.ARADDR_W(32), .RDATA_W(128)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0      (m0.slave),
        .m1      (m1.slave),
        .s       (s.master),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [7:0]  len;
        int          rl;
        logic        exp_gnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic issue_ar(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                            input logic [7:0] len, input int stall, input logic g);
        @(negedge clk);
        m0.arvalid = req[0]; m0.araddr = a0; m0.arlen = len; m0.arburst = 2'b01;
        m1.arvalid = req[1]; m1.araddr = a1; m1.arlen = len; m1.arburst = 2'b10;
        #1;
        chk("m0_arready", m0.arready, !g);
        chk("m1_arready", m1.arready, g);
        chk("s_arvalid_idle", s.arvalid, 0);
        @(negedge clk);
        for (int i = 0; i <= stall; i++) begin
            s.arready = (i == stall);
            #1;
            chk("s_arvalid", s.arvalid, 1);
            chk("s_araddr", s.araddr, g ? a1 : a0);
            chk("s_arlen", s.arlen, len);
            chk("s_arburst", s.arburst, g ? 2'b10 : 2'b01);
            chk("arready_addr", {m1.arready, m0.arready}, 0);
            @(negedge clk);
        end
        s.arready = 0;
        m0.arvalid = 0;
        m1.arvalid = 0;
    endtask

    task automatic beats(input logic g, input int rl);
        for (int b = 0; b <= rl; b++) begin
            s.rvalid = 1; s.rdata = 128'h5A00 + 128'(b); s.rresp = b[1:0]; s.rlast = (b == rl);
            m0.rready = !g; m1.rready = g;
            #1;
            chk("r_valid", g ? m1.rvalid : m0.rvalid, 1);
            chk("r_data", g ? m1.rdata : m0.rdata, 128'h5A00 + 128'(b));
            chk("r_resp", g ? m1.rresp : m0.rresp, b[1:0]);
            chk("r_last", g ? m1.rlast : m0.rlast, b == rl);
            chk("r_other_valid", g ? m0.rvalid : m1.rvalid, 0);
            chk("s_rready", s.rready, 1);
            @(negedge clk);
        end
        s.rvalid = 0; s.rlast = 0; m0.rready = 0; m1.rready = 0;
    endtask

    initial begin
        int got, prev, pulses;
        vecs[0] = '{2'b11, 32'h2000, 32'h3000, 8'd1, 1, 1'b0, 1'b0};
        vecs[1] = '{2'b11, 32'h2010, 32'h3010, 8'd1, 1, 1'b1, 1'b0};
        vecs[2] = '{2'b11, 32'h2020, 32'h3020, 8'd1, 1, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 32'h2030, 32'h3030, 8'd1, 1, 1'b1, 1'b0};
        vecs[4] = '{2'b01, 32'h1000, 32'h0,    8'd3, 3, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 32'h0,    32'h7000, 8'd0, 0, 1'b1, 1'b0};
        vecs[6] = '{2'b01, 32'h1100, 32'h0,    8'd3, 2, 1'b0, 1'b1};
        vecs[7] = '{2'b10, 32'h0,    32'h7100, 8'd2, 2, 1'b1, 1'b1};
        vecs[8] = '{2'b11, 32'h1200, 32'h7200, 8'd0, 0, 1'b0, 1'b1};
        rst = 1;
        m0.arvalid = 0; m0.araddr = 0; m0.arburst = 0; m0.arlen = 0; m0.rready = 0;
        m1.arvalid = 0; m1.araddr = 0; m1.arburst = 0; m1.arlen = 0; m1.rready = 0;
        s.arready = 0; s.rvalid = 0; s.rdata = 0; s.rresp = 0; s.rlast = 0;
        repeat (2) @(negedge clk);
        chk("rst_s_arvalid", s.arvalid, 0);
        chk("rst_s_rready", s.rready, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_s_araddr", s.araddr, 0);
        chk("rst_s_arlen", s.arlen, 0);
        chk("rst_rvalid", {m1.rvalid, m0.rvalid}, 0);
        rst = 0;
        for (int i = 0; i < 9; i++) begin
            issue_ar(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].len, 0, vecs[i].exp_gnt);
            beats(vecs[i].exp_gnt, vecs[i].rl);
            #1;
            chk($sformatf("len_err_v%0d", i), len_err, vecs[i].exp_err);
        end
        // backpressure: AR stalled 5 cycles, M1 RREADY toggling
        issue_ar(2'b10, 32'h0, 32'h4000_0040, 8'd7, 5, 1'b1);
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            s.rvalid = 1; s.rdata = 128'hA0 + 128'(got); s.rlast = (got == 7);
            m1.rready = (c[0] == 1'b0); m0.rready = 1;
            #1;
            chk("bp_s_rready", s.rready, m1.rready);
            chk("bp_rdata", m1.rdata, 128'hA0 + 128'(got));
            chk("bp_m0_rvalid", m0.rvalid, 0);
            if (m1.rready) got++;
            @(negedge clk);
        end
        s.rvalid = 0; s.rlast = 0; m0.rready = 0; m1.rready = 0;
        chk("bp_beats", got, 8);
        #1;
        chk("bp_len_err_sticky", len_err, 1);
        // reset in the middle of an 8-beat burst
        issue_ar(2'b01, 32'h5000, 32'h0, 8'd7, 0, 1'b0);
        s.rvalid = 1; s.rdata = 0; s.rlast = 0; m0.rready = 1;
        @(negedge clk);
        rst = 1; s.rdata = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("mid_rst_s_arvalid", s.arvalid, 0);
        chk("mid_rst_s_rready", s.rready, 0);
        chk("mid_rst_m0_rvalid", m0.rvalid, 0);
        chk("mid_rst_len_err", len_err, 0);
        s.rvalid = 0; m0.rready = 0;
        issue_ar(2'b10, 32'h0, 32'h6000, 8'd1, 0, 1'b1);
        beats(1'b1, 1);
        #1;
        chk("post_rst_len_err", len_err, 0);
        // back-to-back single-beat bursts from M1
        @(negedge clk);
        m1.arvalid = 1; m1.araddr = 32'h8000; m1.arlen = 0; m1.arburst = 2'b01;
        s.arready = 1; s.rvalid = 1; s.rlast = 1; s.rdata = 128'hBEEF; m1.rready = 1;
        prev = -1; pulses = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (s.arvalid) begin
                if (prev >= 0) chk("b2b_gap", 128'(c - prev), 3);
                prev = c;
                pulses++;
            end
            if (m1.rvalid) chk("b2b_rlast", m1.rlast, 1);
            @(negedge clk);
        end
        chk("b2b_pulses", pulses, 4);
        m1.arvalid = 0;
        repeat (3) @(negedge clk);
        s.arready = 0; s.rvalid = 0; s.rlast = 0; m1.rready = 0;
        #1;
        chk("b2b_len_err", len_err, 0);
        chk("b2b_idle_s_arvalid", s.arvalid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
